// File: rtl/button_event_pkg.sv
// Shared constants, status/command bit positions and debounce state type
// for the push-button event capture block.
package button_event_pkg;

  localparam int NUM_BUTTONS = 4;

  localparam int LVL_LSB  = 0;
  localparam int FLAG_LSB = 4;
  localparam int CNT_LSB  = 8;
  localparam int REL_LSB  = 24;
  localparam int ACK_BIT  = 31;

  localparam int CMD_CLRCNT_BIT = 4;
  localparam int CMD_SEQ_BIT    = 31;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } debounce_state_e;

endpackage

// File: rtl/button_debouncer.sv
// One button: synchronizer (resets to released), debounce FSM with stability
// counter, and one-cycle press/release pulses coincident with the level flip.
module button_debouncer
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  debounce_state_e        state;
  logic                   flip;

  assign synced = ~sync_q[SYNC_STAGES-1];

  // The pulses fire in the cycle before the flip edge so that flag/counter
  // updates in the top land on the same edge as the new level.
  assign flip          = (state == PENDING) && (synced != level) && (cnt == CNT_MAX);
  assign press_pulse   = flip && !level;
  assign release_pulse = flip && level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      state  <= STABLE;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      case (state)
        STABLE: begin
          if (synced != level) begin
            state <= PENDING;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        PENDING: begin
          if (synced == level) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            level <= ~level;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_capture.sv
// Debounced KEY levels, sticky press flags and press counters packed into the
// push-button status word; host clears them via a toggle-sequenced command.
// Optional release flags: define BUTTON_RELEASE_EVENT_EN.
module button_event_capture
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_n,
  input  logic [31:0] cmd_word,
  output logic [31:0] status_word
);

  // Command handshake: a command is pending whenever cmd_word[31] differs
  // from ack; it is executed on that edge and ack takes the new sequence bit,
  // so each host toggle is consumed exactly once.

  logic [NUM_BUTTONS-1:0]   level;
  logic [NUM_BUTTONS-1:0]   press_pulse;
  logic [NUM_BUTTONS-1:0]   release_pulse;
  logic [NUM_BUTTONS-1:0]   flags;
  logic [NUM_BUTTONS*4-1:0] counts;
  logic [NUM_BUTTONS-1:0]   rel_flags;
  logic                     ack;

  logic                     cmd_pending;
  logic [NUM_BUTTONS-1:0]   clr_mask;
  logic                     clr_cnt;
  logic                     unused_cmd_bits;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_debouncer (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

  assign cmd_pending     = cmd_word[CMD_SEQ_BIT] != ack;
  assign clr_mask        = cmd_pending ? cmd_word[NUM_BUTTONS-1:0] : '0;
  assign clr_cnt         = cmd_pending && cmd_word[CMD_CLRCNT_BIT];
  assign unused_cmd_bits = ^cmd_word[30:5];

  // Clear is applied first and the press on top of it, so set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags  <= '0;
      counts <= '0;
      ack    <= 1'b0;
    end else begin
      if (cmd_pending) ack <= cmd_word[CMD_SEQ_BIT];
      flags <= (flags & ~clr_mask) | press_pulse;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        counts[4*i +: 4] <= (clr_cnt ? 4'd0 : counts[4*i +: 4]) + {3'b000, press_pulse[i]};
      end
    end
  end

`ifdef BUTTON_RELEASE_EVENT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_flags <= '0;
    end else begin
      rel_flags <= (rel_flags & ~clr_mask) | release_pulse;
    end
  end
`else
  logic unused_release;
  assign unused_release = |release_pulse;
  assign rel_flags      = '0;
`endif

  always_comb begin
    status_word                            = '0;
    status_word[LVL_LSB  +: NUM_BUTTONS]   = level;
    status_word[FLAG_LSB +: NUM_BUTTONS]   = flags;
    status_word[CNT_LSB  +: NUM_BUTTONS*4] = counts;
    status_word[REL_LSB  +: NUM_BUTTONS]   = rel_flags;
    status_word[ACK_BIT]                   = ack;
  end

endmodule

// File: tb/tb_button_event_capture.sv
// Directed bench for button_event_capture (DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
// with a cycle-stamped expected queue checked by an independent monitor.
module tb_button_event_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [31:0] cmd_word;
  logic [31:0] status_word;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          tgt_q[$];
  string       name_q[$];

`ifdef BUTTON_RELEASE_EVENT_EN
  localparam logic [3:0] REL_MASK = 4'hF;
`else
  localparam logic [3:0] REL_MASK = 4'h0;
`endif

  button_event_capture #(
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .cmd_word   (cmd_word),
    .status_word(status_word)
  );

  // Clock and cycle stamp: cyc counts rising edges.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rel(input logic [3:0] r);
    return {4'h0, r & REL_MASK, 24'h0};
  endfunction

  // Driver helpers: inputs change 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int n, input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    tgt_q.push_back(cyc + n);
    name_q.push_back(nm);
  endtask

  // Monitor: on each falling edge, compare every expectation that is due.
  initial begin
    forever begin
      @(negedge clk);
      while (tgt_q.size() > 0 && tgt_q[0] <= cyc) begin
        logic [31:0] e;
        int          t;
        string       nm;
        e  = exp_q.pop_front();
        t  = tgt_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (t != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", nm, t, cyc);
        end else if (status_word !== e) begin
          errors++;
          $display("FAIL %s: cycle %0d status_word got %h expected %h", nm, cyc, status_word, e);
        end
      end
    end
  end

  initial begin
    int drain;
    reset    = 1'b1;
    key_n    = 4'hF;
    cmd_word = 32'h0;

    // 1. Reset held 3 cycles, then quiet for 50.
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_at(0, 32'h0, "reset_hold");
    end
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) expect_at(i * 10, 32'h0, "reset_quiet");
    step(50);

    // 2. Clean press and release of button 0.
    key_n = 4'hE;
    expect_at(9,  32'h0000_0000, "press0_early");
    expect_at(10, 32'h0000_0111, "press0_level");
    step(20);
    key_n = 4'hF;
    expect_at(9,  32'h0000_0111, "release0_early");
    expect_at(10, 32'h0000_0110 | rel(4'h1), "release0_level");
    step(20);

    // 3. Bounce rejection on button 2.
    key_n = 4'hB;
    step(5);
    key_n = 4'hF;
    expect_at(5,  32'h0000_0110 | rel(4'h1), "glitch5_a");
    expect_at(15, 32'h0000_0110 | rel(4'h1), "glitch5_b");
    step(20);
    key_n = 4'hB;
    step(7);
    key_n = 4'hF;
    step(1);
    key_n = 4'hB;
    expect_at(9,  32'h0000_0110 | rel(4'h1), "bounce2_early");
    expect_at(10, 32'h0001_0154 | rel(4'h1), "bounce2_level");
    step(20);
    key_n = 4'hF;
    expect_at(10, 32'h0001_0150 | rel(4'h5), "release2");
    step(20);

    // 4. Clear handshake with all flags set.
    key_n = 4'h5;
    expect_at(10, 32'h0011_11FA | rel(4'h5), "press13");
    step(20);
    key_n = 4'hF;
    expect_at(10, 32'h0011_11F0 | rel(4'hF), "release13");
    step(20);
    cmd_word = 32'h8000_0005;
    expect_at(0,  32'h0011_11F0 | rel(4'hF), "clr_before");
    expect_at(1,  32'h8011_11A0 | rel(4'hA), "clr_mask5");
    expect_at(20, 32'h8011_11A0 | rel(4'hA), "clr_once");
    step(20);
    cmd_word = 32'h0000_0010;
    expect_at(1,  32'h0000_00A0 | rel(4'hA), "clr_counts");
    step(10);

    // 5. Clear landing on the same edge as the press flip of button 1.
    key_n = 4'hD;
    step(9);
    cmd_word = 32'h8000_0012;
    expect_at(0, 32'h0000_00A0 | rel(4'hA), "coll_before");
    expect_at(1, 32'h8000_10A2 | rel(4'h8), "coll_cnt_clr");
    step(11);
    key_n = 4'hF;
    expect_at(10, 32'h8000_10A0 | rel(4'hA), "coll_release");
    step(20);
    key_n = 4'hD;
    step(9);
    cmd_word = 32'h0000_0002;
    expect_at(1, 32'h0000_20A2 | rel(4'h8), "coll_flag");
    step(11);
    key_n = 4'hF;
    expect_at(10, 32'h0000_20A0 | rel(4'hA), "coll_release2");
    step(20);

    // 6. Sixteen presses on button 3 wrap its counter to 0.
    cmd_word = 32'h8000_0008;
    expect_at(1, 32'h8000_2020 | rel(4'h2), "clr_flag3");
    step(5);
    for (int k = 0; k < 16; k++) begin
      key_n = 4'h7;
      expect_at(10, 32'h8000_20A8 | (32'((k + 1) % 16) << 20) | rel(k == 0 ? 4'h2 : 4'hA),
                "wrap_press");
      step(20);
      key_n = 4'hF;
      step(20);
    end
    expect_at(0, 32'h8000_20A0 | rel(4'hA), "wrap_final");
    step(1);

    // Reset with a pending command: it runs on the first edge after reset.
    reset = 1'b1;
    step(1);
    expect_at(0, 32'h0, "reset_mid");
    reset = 1'b0;
    expect_at(0, 32'h0, "reset_release");
    expect_at(1, 32'h8000_0000, "reset_cmd");
    step(3);

    drain = 0;
    while (tgt_q.size() > 0 && drain < 200) begin
      step(1);
      drain++;
    end
    if (tgt_q.size() > 0) begin
      errors += tgt_q.size();
      $display("FAIL drain: %0d expectations never checked, required 0", tgt_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
